// File: rtl/alu_nibble_sequencer_pkg.sv
// rtl/alu_nibble_sequencer_pkg.sv - shared types and ALU select constants for the nibble sequencer
package alu_nibble_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // XOR shares its select code with SUB; M picks logic vs arithmetic.
    localparam logic [3:0] ALU_S_ADD = 4'b1001;
    localparam logic [3:0] ALU_S_SUB = 4'b0110;
    localparam logic [3:0] ALU_S_XOR = 4'b0110;
    localparam logic [3:0] ALU_S_AND = 4'b1011;

    function automatic int cnt_width(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// rtl/alu_nibble_sequencer_if.sv - request, result and ALU-slice signal bundle for the sequencer
interface alu_nibble_sequencer_if #(parameter int NIBBLES = 2);

    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [3:0]   op_s;
    logic         op_m;
    logic         op_cnb;

    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic [3:0]   alu_s;
    logic         alu_m;
    logic         alu_cnb;
    logic [3:0]   alu_f;
    logic         alu_cn4b;
    logic         alu_aeb;

    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_f;
    logic         res_cn4b;
    logic         res_aeb;
    logic         busy;

    modport master (
        output in_valid, op_a, op_b, op_s, op_m, op_cnb, res_ready,
        output alu_f, alu_cn4b, alu_aeb,
        input  in_ready, res_valid, res_f, res_cn4b, res_aeb, busy,
        input  alu_a, alu_b, alu_s, alu_m, alu_cnb
    );

    modport slave (
        input  in_valid, op_a, op_b, op_s, op_m, op_cnb, res_ready,
        input  alu_f, alu_cn4b, alu_aeb,
        output in_ready, res_valid, res_f, res_cn4b, res_aeb, busy,
        output alu_a, alu_b, alu_s, alu_m, alu_cnb
    );

endinterface

// File: rtl/alu_nibble_sequencer.sv
// rtl/alu_nibble_sequencer.sv - time-multiplexes one 4-bit ALU slice over a NIBBLES-wide operation
module alu_nibble_sequencer
    import alu_nibble_sequencer_pkg::*;
#(
    parameter int NIBBLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_nibble_sequencer_if.slave bus
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = cnt_width(NIBBLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

    state_e        state_q, state_d;
    logic [W-1:0]  a_sh_q, a_sh_d;
    logic [W-1:0]  b_sh_q, b_sh_d;
    logic [W-1:0]  f_sh_q, f_sh_d;
    logic [3:0]    s_q, s_d;
    logic          m_q, m_d;
    logic          carry_q, carry_d;
    logic          aeb_q, aeb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_ready_q, in_ready_d;
    logic          busy_q, busy_d;
    logic          res_valid_q, res_valid_d;

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        f_sh_d      = f_sh_q;
        s_d         = s_q;
        m_d         = m_q;
        carry_d     = carry_q;
        aeb_d       = aeb_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        res_valid_d = res_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_sh_d     = bus.op_a;
                    b_sh_d     = bus.op_b;
                    s_d        = bus.op_s;
                    m_d        = bus.op_m;
                    carry_d    = bus.op_cnb;
                    aeb_d      = 1'b1;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                // Result fills from the top so the first (LSB) nibble lands at [3:0] after NIBBLES shifts.
                f_sh_d  = (f_sh_q >> 4) | (W'(bus.alu_f) << (W - 4));
                a_sh_d  = a_sh_q >> 4;
                b_sh_d  = b_sh_q >> 4;
                carry_d = bus.alu_cn4b;
                aeb_d   = aeb_q & bus.alu_aeb;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                res_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            f_sh_q      <= '0;
            s_q         <= '0;
            m_q         <= 1'b0;
            carry_q     <= 1'b1;
            aeb_q       <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            f_sh_q      <= f_sh_d;
            s_q         <= s_d;
            m_q         <= m_d;
            carry_q     <= carry_d;
            aeb_q       <= aeb_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.busy      = busy_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_f     = f_sh_q;
    assign bus.res_cn4b  = carry_q;
    assign bus.res_aeb   = aeb_q;
    assign bus.alu_a     = a_sh_q[3:0];
    assign bus.alu_b     = b_sh_q[3:0];
    assign bus.alu_s     = s_q;
    assign bus.alu_m     = m_q;
    assign bus.alu_cnb   = carry_q;

endmodule
